// File: rtl/mem_pkg.sv
// Shared types and defaults for the load/store memory port arbiter.
package mem_pkg;

  localparam int unsigned TAG_W          = 6;
  localparam int unsigned DEF_ADDR_LIMIT = 1024;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_addr_check.sv
// Flags a word access that is misaligned or runs past the end of data memory.
module mem_addr_check
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = DEF_ADDR_LIMIT
) (
  input  logic [31:0] addr,
  output logic        bad
);

  localparam logic [31:0] LAST_WORD = 32'(ADDR_LIMIT - 4);

  assign bad = (addr[1:0] != 2'b00) || (addr > LAST_WORD);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port data-memory arbiter: loads beat stores except on a same-word RAW hazard.
// Optional store starvation guard enabled with STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT   = DEF_ADDR_LIMIT,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_addr,
  input  logic [TAG_W-1:0] ld_tag,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic             flush,
  output logic             resp_valid,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      resp_data,
  output logic             resp_err,
  output logic [31:0]      mem_address,
  output logic             mem_read,
  output logic             mem_write,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  arb_state_e       state_q, state_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic             resp_err_q, resp_err_d;

  logic ld_bad, st_bad;
  logic same_word, st_win, blocked;
  logic starve_force;

  mem_addr_check #(.ADDR_LIMIT(ADDR_LIMIT)) u_ld_chk (.addr(ld_addr), .bad(ld_bad));
  mem_addr_check #(.ADDR_LIMIT(ADDR_LIMIT)) u_st_chk (.addr(st_addr), .bad(st_bad));

  assign same_word = (ld_addr[31:2] == st_addr[31:2]);

`ifdef STARVE_GUARD_EN
  localparam logic [2:0] STARVE_TC = 3'(STARVE_LIMIT);

  logic [2:0] starve_cnt_q, starve_cnt_d;

  assign starve_force = (starve_cnt_q >= STARVE_TC);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!st_valid || st_ready) begin
      starve_cnt_d = 3'd0;
    end else if (ld_ready && (starve_cnt_q != 3'd7)) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt_q <= 3'd0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`else
  assign starve_force = 1'b0;
`endif

  // A same-word store must land before the load reads, or the load sees stale data.
  always_comb begin
    blocked  = rst || flush;
    st_win   = st_valid && (!ld_valid || same_word || starve_force);
    ld_ready = ld_valid && !st_win && !blocked;
    st_ready = st_win && !blocked;
  end

  always_comb begin
    mem_read    = ld_ready && !ld_bad;
    mem_write   = st_ready && !st_bad;
    mem_address = 32'h0;
    mem_wdata   = 32'h0;
    if (mem_read) begin
      mem_address = ld_addr;
    end else if (mem_write) begin
      mem_address = st_addr;
      mem_wdata   = st_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    resp_tag_d = resp_tag_q;
    resp_err_d = 1'b0;
    if (ld_ready) begin
      resp_tag_d = ld_tag;
      resp_err_d = ld_bad;
    end
    case (state_q)
      IDLE:    if (ld_ready) state_d = RESP;
      RESP:    state_d = ld_ready ? RESP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      resp_tag_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_tag_q <= resp_tag_d;
      resp_err_q <= resp_err_d;
    end
  end

  // Memory read data arrives one cycle after mem_read, lining up with RESP.
  assign resp_valid = (state_q == RESP) && !flush;
  assign resp_tag   = resp_tag_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_err_q ? 32'h0 : mem_rdata;

endmodule
